// File: rtl/chimera_pkg.sv
// Shared types and defaults for the Chimera cluster power sequencer.
package chimera_pkg;

    typedef enum logic [2:0] {
        PWR_ON    = 3'd0,
        PWR_ISO   = 3'd1,
        PWR_RST   = 3'd2,
        PWR_OFF   = 3'd3,
        PWR_WAKE  = 3'd4,
        PWR_DEISO = 3'd5
    } cluster_pwr_state_e;

    localparam int unsigned DefaultRstHoldCycles = 8;
    localparam int unsigned DefaultIsoTimeout    = 64;

    // Counter wide enough for both the reset hold and the isolation timeout.
    function automatic int unsigned cnt_width(int unsigned rst_hold, int unsigned iso_timeout);
        return $clog2(((rst_hold > iso_timeout) ? rst_hold : iso_timeout) + 1);
    endfunction

endpackage

// File: rtl/chimera_cluster_pwr_fsm.sv
// Single-cluster power sequencer: isolate -> reset -> gate on the way down,
// ungate -> reset hold -> release -> de-isolate on the way up.
module chimera_cluster_pwr_fsm
    import chimera_pkg::*;
#(
    parameter bit          BootOn        = 1'b1,
    parameter int unsigned RstHoldCycles = DefaultRstHoldCycles,
    parameter int unsigned IsoTimeout    = DefaultIsoTimeout
) (
    input  logic soc_clk_i,
    input  logic rst_i,
    input  logic pwr_req_i,
    input  logic err_clr_i,
    input  logic iso_ack_i,
    output logic rst_cluster_no,
    output logic clkgate_en_o,
    output logic iso_en_o,
    output logic pwr_on_o,
    output logic busy_o,
    output logic err_o
);

    localparam int unsigned CntW = cnt_width(RstHoldCycles, IsoTimeout);
    localparam logic [CntW-1:0] RstLast = CntW'(RstHoldCycles - 1);
    localparam logic [CntW-1:0] IsoLast = CntW'(IsoTimeout - 1);
    localparam cluster_pwr_state_e BootState = BootOn ? PWR_ON : PWR_OFF;

    cluster_pwr_state_e state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic               err_set, iso_timeout;

    assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign iso_timeout = (IsoTimeout != 0) && (cnt_q == IsoLast);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        unique case (state_q)
            PWR_ON: begin
                if (!pwr_req_i) begin
                    state_d = PWR_ISO;
                    cnt_d   = '0;
                end
            end
            PWR_ISO: begin
                if (iso_ack_i || iso_timeout) begin
                    state_d = PWR_RST;
                    cnt_d   = '0;
                    err_set = !iso_ack_i;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PWR_RST: begin
                if (cnt_q == RstLast) begin
                    state_d = PWR_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PWR_OFF: begin
                if (pwr_req_i) begin
                    state_d = PWR_WAKE;
                    cnt_d   = '0;
                end
            end
            PWR_WAKE: begin
                if (cnt_q == RstLast) begin
                    state_d = PWR_DEISO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PWR_DEISO: begin
                if (!iso_ack_i || iso_timeout) begin
                    state_d = PWR_ON;
                    cnt_d   = '0;
                    err_set = iso_ack_i;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = BootState;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge soc_clk_i) begin
        if (rst_i) begin
            state_q <= BootState;
            cnt_q   <= '0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_o   <= (err_o & ~err_clr_i) | err_set;
        end
    end

    // Moore decode: outputs depend on the registered state only.
    always_comb begin
        rst_cluster_no = 1'b0;
        clkgate_en_o   = 1'b0;
        iso_en_o       = 1'b1;
        unique case (state_q)
            PWR_ON:    begin rst_cluster_no = 1'b1; iso_en_o = 1'b0; end
            PWR_ISO:   begin rst_cluster_no = 1'b1; end
            PWR_RST:   begin end
            PWR_OFF:   begin clkgate_en_o = 1'b1; end
            PWR_WAKE:  begin end
            PWR_DEISO: begin rst_cluster_no = 1'b1; iso_en_o = 1'b0; end
            default:   begin end
        endcase
    end

    assign pwr_on_o = (state_q == PWR_ON);
    assign busy_o   = (state_q != PWR_ON) && (state_q != PWR_OFF);

endmodule

// File: rtl/chimera_cluster_pwr_seq.sv
// Per-cluster power sequencer array with a shared error interrupt.
module chimera_cluster_pwr_seq
    import chimera_pkg::*;
#(
    parameter int unsigned          NumClusters   = 5,
    parameter logic [NumClusters-1:0] BootOnMask  = '1,
    parameter int unsigned          RstHoldCycles = DefaultRstHoldCycles,
    parameter int unsigned          IsoTimeout    = DefaultIsoTimeout
) (
    input  logic                   soc_clk_i,
    input  logic                   rst_i,
    input  logic [NumClusters-1:0] pwr_req_i,
    input  logic [NumClusters-1:0] err_clr_i,
    input  logic [NumClusters-1:0] iso_ack_i,
    output logic [NumClusters-1:0] rst_clusters_no,
    output logic [NumClusters-1:0] clkgate_en_o,
    output logic [NumClusters-1:0] iso_en_o,
    output logic [NumClusters-1:0] pwr_on_o,
    output logic [NumClusters-1:0] busy_o,
    output logic [NumClusters-1:0] err_o,
    output logic                   irq_o
);

    for (genvar c = 0; c < NumClusters; c++) begin : g_cluster
        chimera_cluster_pwr_fsm #(
            .BootOn        (BootOnMask[c]),
            .RstHoldCycles (RstHoldCycles),
            .IsoTimeout    (IsoTimeout)
        ) u_fsm (
            .soc_clk_i      (soc_clk_i),
            .rst_i          (rst_i),
            .pwr_req_i      (pwr_req_i[c]),
            .err_clr_i      (err_clr_i[c]),
            .iso_ack_i      (iso_ack_i[c]),
            .rst_cluster_no (rst_clusters_no[c]),
            .clkgate_en_o   (clkgate_en_o[c]),
            .iso_en_o       (iso_en_o[c]),
            .pwr_on_o       (pwr_on_o[c]),
            .busy_o         (busy_o[c]),
            .err_o          (err_o[c])
        );
    end

    always_ff @(posedge soc_clk_i) begin
        if (rst_i) irq_o <= 1'b0;
        else       irq_o <= |err_o;
    end

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Table-driven scoreboard bench for chimera_cluster_pwr_seq (5 clusters, boot mask 00101).
module tb_chimera_cluster_pwr_seq;

    logic       soc_clk_i = 1'b0;
    logic       rst_i     = 1'b1;
    logic [4:0] pwr_req_i = 5'b00101;
    logic [4:0] err_clr_i = 5'b00000;
    logic [4:0] iso_ack_i = 5'b11010;
    logic [4:0] rst_clusters_no, clkgate_en_o, iso_en_o, pwr_on_o, busy_o, err_o;
    logic       irq_o;

    chimera_cluster_pwr_seq #(
        .NumClusters   (5),
        .BootOnMask    (5'b00101),
        .RstHoldCycles (8),
        .IsoTimeout    (64)
    ) dut (
        .soc_clk_i       (soc_clk_i),
        .rst_i           (rst_i),
        .pwr_req_i       (pwr_req_i),
        .err_clr_i       (err_clr_i),
        .iso_ack_i       (iso_ack_i),
        .rst_clusters_no (rst_clusters_no),
        .clkgate_en_o    (clkgate_en_o),
        .iso_en_o        (iso_en_o),
        .pwr_on_o        (pwr_on_o),
        .busy_o          (busy_o),
        .err_o           (err_o),
        .irq_o           (irq_o)
    );

    initial forever #5 soc_clk_i = ~soc_clk_i;

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] req;
        logic [4:0] ack;
        logic [4:0] clr;
        int         cycles;
        string      st;    // one letter per cluster, cluster 4 first
        logic [4:0] err;
        logic       irq;
    } vec_t;

    typedef struct {
        string       name;
        logic [30:0] word;
    } exp_t;

    vec_t tbl1[$];
    vec_t tbl2[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // N=ON I=ISO R=RST F=OFF W=WAKE D=DEISO, decoded from the output table.
    function automatic logic [30:0] expect_word(string st, logic [4:0] err, logic irq);
        logic [4:0] rn, cg, is, po, bz;
        byte ch;
        rn = '0; cg = '0; is = '0; po = '0; bz = '0;
        for (int c = 0; c < 5; c++) begin
            ch = st[4-c];
            case (ch)
                "N": begin rn[c] = 1'b1; po[c] = 1'b1; end
                "I": begin rn[c] = 1'b1; is[c] = 1'b1; bz[c] = 1'b1; end
                "R": begin is[c] = 1'b1; bz[c] = 1'b1; end
                "F": begin cg[c] = 1'b1; is[c] = 1'b1; end
                "W": begin is[c] = 1'b1; bz[c] = 1'b1; end
                "D": begin rn[c] = 1'b1; bz[c] = 1'b1; end
                default: begin rn[c] = 1'bx; end
            endcase
        end
        return {rn, cg, is, po, bz, err, irq};
    endfunction

    function automatic void add(int which, string name, logic r, logic [4:0] req, logic [4:0] ack,
                                logic [4:0] clr, int cyc, string st, logic [4:0] err, logic irq);
        vec_t v;
        v.name = name; v.rst = r; v.req = req; v.ack = ack; v.clr = clr;
        v.cycles = cyc; v.st = st; v.err = err; v.irq = irq;
        if (which == 1) tbl1.push_back(v);
        else            tbl2.push_back(v);
    endfunction

    task automatic run(input vec_t v);
        exp_t e;
        rst_i     = v.rst;
        pwr_req_i = v.req;
        iso_ack_i = v.ack;
        err_clr_i = v.clr;
        repeat (v.cycles) @(posedge soc_clk_i);
        #1;
        e.name = v.name;
        e.word = expect_word(v.st, v.err, v.irq);
        sb.push_back(e);
    endtask

    // Scoreboard drain plus the sequencing invariant: a gated clock implies reset and
    // isolation, and an asserted reset implies isolation.
    always @(negedge soc_clk_i) begin
        logic [4:0] bad;
        exp_t       e;
        bad = (clkgate_en_o & (rst_clusters_no | ~iso_en_o)) | (~rst_clusters_no & ~iso_en_o);
        check("order", 64'(bad), 64'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, 64'({rst_clusters_no, clkgate_en_o, iso_en_o, pwr_on_o, busy_o, err_o, irq_o}),
                  64'(e.word));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        // reset, cluster0 power-down, cluster1 power-up, cluster1 enters ISO
        add(1, "reset",         1, 5'b00101, 5'b11010, 5'b00000, 2, "FFNFN", 5'b00000, 0);
        add(1, "idle",          0, 5'b00101, 5'b11010, 5'b00000, 3, "FFNFN", 5'b00000, 0);
        add(1, "c0_iso",        0, 5'b00100, 5'b11010, 5'b00000, 1, "FFNFI", 5'b00000, 0);
        add(1, "c0_iso_wait",   0, 5'b00100, 5'b11010, 5'b00000, 2, "FFNFI", 5'b00000, 0);
        add(1, "c0_rst",        0, 5'b00100, 5'b11011, 5'b00000, 1, "FFNFR", 5'b00000, 0);
        add(1, "c0_rst_hold",   0, 5'b00100, 5'b11011, 5'b00000, 7, "FFNFR", 5'b00000, 0);
        add(1, "c0_off",        0, 5'b00100, 5'b11011, 5'b00000, 1, "FFNFF", 5'b00000, 0);
        add(1, "c1_wake",       0, 5'b00110, 5'b11011, 5'b00000, 1, "FFNWF", 5'b00000, 0);
        add(1, "c1_wake_hold",  0, 5'b00110, 5'b11011, 5'b00000, 7, "FFNWF", 5'b00000, 0);
        add(1, "c1_deiso",      0, 5'b00110, 5'b11011, 5'b00000, 1, "FFNDF", 5'b00000, 0);
        add(1, "c1_deiso_wait", 0, 5'b00110, 5'b11011, 5'b00000, 2, "FFNDF", 5'b00000, 0);
        add(1, "c1_on",         0, 5'b00110, 5'b11001, 5'b00000, 1, "FFNNF", 5'b00000, 0);
        add(1, "c1_iso_to",     0, 5'b00100, 5'b11001, 5'b00000, 1, "FFNIF", 5'b00000, 0);
        // err clear, DEISO timeout with coincident clear, req glitch, mid-sequence reset, all-off
        add(2, "err_clr",       0, 5'b00100, 5'b11001, 5'b00010, 1, "FFNRF", 5'b00000, 1);
        add(2, "irq_clr",       0, 5'b00100, 5'b11001, 5'b00000, 1, "FFNRF", 5'b00000, 0);
        add(2, "c1_rst_hold",   0, 5'b00100, 5'b11001, 5'b00000, 4, "FFNRF", 5'b00000, 0);
        add(2, "c1_off",        0, 5'b00100, 5'b11011, 5'b00000, 1, "FFNFF", 5'b00000, 0);
        add(2, "c1_wake2",      0, 5'b00110, 5'b11011, 5'b00000, 1, "FFNWF", 5'b00000, 0);
        add(2, "c1_deiso2",     0, 5'b00110, 5'b11011, 5'b00000, 8, "FFNDF", 5'b00000, 0);
        add(2, "c1_deiso_to",   0, 5'b00110, 5'b11011, 5'b00000, 63, "FFNDF", 5'b00000, 0);
        add(2, "set_wins",      0, 5'b00110, 5'b11011, 5'b00010, 1, "FFNNF", 5'b00010, 0);
        add(2, "irq_set2",      0, 5'b00110, 5'b11001, 5'b00000, 1, "FFNNF", 5'b00010, 1);
        add(2, "c2_drop",       0, 5'b00010, 5'b11001, 5'b00000, 1, "FFINF", 5'b00010, 1);
        add(2, "c2_req_back",   0, 5'b00110, 5'b11101, 5'b00000, 1, "FFRNF", 5'b00010, 1);
        add(2, "c2_rst_hold",   0, 5'b00110, 5'b11101, 5'b00000, 7, "FFRNF", 5'b00010, 1);
        add(2, "c2_off",        0, 5'b00110, 5'b11101, 5'b00000, 1, "FFFNF", 5'b00010, 1);
        add(2, "c2_rewake",     0, 5'b00110, 5'b11101, 5'b00000, 1, "FFWNF", 5'b00010, 1);
        add(2, "c2_deiso",      0, 5'b00110, 5'b11101, 5'b00000, 8, "FFDNF", 5'b00010, 1);
        add(2, "c2_on",         0, 5'b00110, 5'b11001, 5'b00000, 1, "FFNNF", 5'b00010, 1);
        add(2, "c3_wake",       0, 5'b01110, 5'b11001, 5'b00000, 1, "FWNNF", 5'b00010, 1);
        add(2, "c3_wake_cnt4",  0, 5'b01110, 5'b11001, 5'b00000, 4, "FWNNF", 5'b00010, 1);
        add(2, "rst_mid",       1, 5'b01110, 5'b11001, 5'b00000, 1, "FFNFN", 5'b00000, 0);
        add(2, "post_rst",      0, 5'b00101, 5'b11010, 5'b00000, 1, "FFNFN", 5'b00000, 0);
        add(2, "all_wake",      0, 5'b11111, 5'b11010, 5'b00000, 1, "WWNWN", 5'b00000, 0);
        add(2, "all_deiso",     0, 5'b11111, 5'b11010, 5'b00000, 8, "DDNDN", 5'b00000, 0);
        add(2, "all_on",        0, 5'b11111, 5'b00000, 5'b00000, 1, "NNNNN", 5'b00000, 0);
        add(2, "all_iso",       0, 5'b00000, 5'b00000, 5'b00000, 1, "IIIII", 5'b00000, 0);
        add(2, "all_rst",       0, 5'b00000, 5'b11111, 5'b00000, 1, "RRRRR", 5'b00000, 0);
        add(2, "all_rst_hold",  0, 5'b00000, 5'b11111, 5'b00000, 7, "RRRRR", 5'b00000, 0);
        add(2, "all_off",       0, 5'b00000, 5'b11111, 5'b00000, 1, "FFFFF", 5'b00000, 0);

        foreach (tbl1[i]) run(tbl1[i]);

        // Cluster1 sits in ISO with no ack: count edges until the timeout forces RST.
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge soc_clk_i);
            #1;
            n++;
            if (!rst_clusters_no[1]) break;
        end
        check("iso_timeout_len", 64'(n), 64'd64);
        check("timeout_err", 64'(err_o), 64'h02);
        check("irq_lag", 64'(irq_o), 64'd0);
        @(posedge soc_clk_i);
        #1;
        check("irq_set", 64'(irq_o), 64'd1);

        foreach (tbl2[i]) run(tbl2[i]);

        @(negedge soc_clk_i);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
